// File: rtl/jump_pkg.sv
// Shared definitions for the jump controller: request priority encoding,
// default return-stack depth and the assembler-generated target table.
package jump_pkg;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_BR,
    REQ_JMP,
    REQ_CALL,
    REQ_RET
  } req_t;

  localparam int RAS_DEPTH_DEF = 4;

  localparam int TABLE_W = 12;
  localparam int TABLE_N = 32;

  // Regenerated by the assembler; entry i is the absolute address of jump label i.
  localparam logic [TABLE_W-1:0] TARGET_TABLE [TABLE_N] = '{
    12'h400, 12'h413, 12'h426, 12'h439, 12'h44C, 12'h45F, 12'h472, 12'h485,
    12'h498, 12'h4AB, 12'h4BE, 12'h4D1, 12'h4E4, 12'h4F7, 12'h50A, 12'h51D,
    12'h530, 12'h543, 12'h556, 12'h569, 12'h57C, 12'h58F, 12'h5A2, 12'h5B5,
    12'h5C8, 12'h5DB, 12'h5EE, 12'h601, 12'h614, 12'h627, 12'h63A, 12'h64D
  };

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-target lookup; indices beyond the generated table read as zero.
import jump_pkg::*;

module jump_lut #(
  parameter int D     = 12,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] lut_idx,
  output logic [D-1:0]     target
);

  always_comb begin
    target = '0;
    for (int i = 0; i < TABLE_N; i++) begin
      if (int'(lut_idx) == i) target = D'(TARGET_TABLE[i]);
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow resolver feeding the program counter, with a return-address stack.
// Optional JUMP_CTRL_REL_EN: jmp_en with lut_idx MSB set becomes a PC-relative jump.
import jump_pkg::*;

module jump_ctrl #(
  parameter int D         = 12,
  parameter int LUT_W     = 5,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [D-1:0]     prog_ctr,
  input  logic             br_en,
  input  logic             br_cond,
  input  logic             jmp_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [LUT_W-1:0] lut_idx,
  output logic             absjump_en,
  output logic [D-1:0]     target,
  output logic             flush,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_err
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] sp;
  logic [D-1:0]  stack [RAS_DEPTH];
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic [D-1:0]  top_entry;
  logic [D-1:0]  ret_addr;
  logic [D-1:0]  lut_target;
  req_t          req;
  logic          do_push;
  logic          do_pop;
  logic          set_err;

  jump_lut #(.D(D), .LUT_W(LUT_W)) u_lut (
    .lut_idx (lut_idx),
    .target  (lut_target)
  );

  // The pointer carries one extra bit so full and empty are distinguishable.
  assign ras_empty = (sp == '0);
  assign ras_full  = (sp == PW'(RAS_DEPTH));
  assign push_idx  = sp[IW-1:0];
  assign top_idx   = sp[IW-1:0] - IW'(1);
  assign top_entry = stack[top_idx];
  assign ret_addr  = prog_ctr + D'(1);

`ifdef JUMP_CTRL_REL_EN
  logic [D-1:0] rel_off;
  logic [D-1:0] rel_target;
  assign rel_off    = {{(D-LUT_W+1){lut_idx[LUT_W-2]}}, lut_idx[LUT_W-2:0]};
  assign rel_target = prog_ctr + rel_off;
`endif

  always_comb begin
    req = REQ_NONE;
    if (ret_en)       req = REQ_RET;
    else if (call_en) req = REQ_CALL;
    else if (jmp_en)  req = REQ_JMP;
    else if (br_en)   req = REQ_BR;
  end

  always_comb begin
    absjump_en = 1'b0;
    target     = '0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    set_err    = 1'b0;
    unique case (req)
      REQ_RET: begin
        if (!ras_empty) begin
          absjump_en = 1'b1;
          target     = top_entry;
          do_pop     = 1'b1;
        end else begin
          set_err = 1'b1;
        end
      end
      REQ_CALL: begin
        absjump_en = 1'b1;
        target     = lut_target;
        if (ras_full) set_err = 1'b1;
        else          do_push = 1'b1;
      end
      REQ_JMP: begin
        absjump_en = 1'b1;
        target     = lut_target;
`ifdef JUMP_CTRL_REL_EN
        if (lut_idx[LUT_W-1]) target = rel_target;
`endif
      end
      REQ_BR: begin
        absjump_en = br_cond;
        target     = lut_target;
      end
      default: begin
        absjump_en = 1'b0;
        target     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp      <= '0;
      flush   <= 1'b0;
      ras_err <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else begin
      flush <= absjump_en;
      if (set_err) ras_err <= 1'b1;
      if (do_push) begin
        stack[push_idx] <= ret_addr;
        sp              <= sp + PW'(1);
      end else if (do_pop) begin
        sp <= sp - PW'(1);
      end
    end
  end

endmodule
